// File: rtl/clkdiv_pkg.sv
// Shared definitions for the programmable clock divider: controller states,
// the smallest legal divide ratio and the default counter width.
package clkdiv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PEND
  } state_e;

  localparam int unsigned DIV_MIN   = 2;
  localparam int unsigned CNT_W_DEF = 4;

endpackage

// File: rtl/clkdiv_core.sv
// Period counter and 50%-duty output stage: pos_q covers the first floor(N/2)
// cycles, and the negedge copy stretches the high phase by half a cycle for odd N.
module clkdiv_core
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [CNT_W-1:0] div,
  input  logic             run,
  output logic             wrap,
  output logic             clk_out
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q;
  logic             pos_q, pos_d;
  logic             neg_q;

  // 'run' is the running request for the next cycle, so pos_q can rise in the
  // same cycle the period starts. Whenever cnt_d is 0 the high phase is active
  // for any legal ratio, so the current div is sufficient across a ratio change.
  always_comb begin
    wrap  = run_q && (cnt_q == (div - ONE));
    cnt_d = (run_q && !wrap) ? (cnt_q + ONE) : '0;
    pos_d = run && (cnt_d < (div >> 1));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      pos_q <= 1'b0;
    end else begin
      run_q <= run;
      cnt_q <= cnt_d;
      pos_q <= pos_d;
    end
  end

  always_ff @(negedge clk or negedge rstn) begin
    if (!rstn) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q;
    end
  end

  assign clk_out = pos_q | (div[0] & neg_q);

endmodule

// File: rtl/clkdiv_ctrl.sv
// Run/stop controller with handshaked ratio reconfiguration; new ratios take
// effect only at output-period boundaries so clk_out never produces a short pulse.
module clkdiv_ctrl
  import clkdiv_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEF,
  parameter int unsigned DEF_DIV = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             period_tick,
  output logic [CNT_W-1:0] div_cur,
  output logic             running
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] DIV_LO  = CNT_W'(DIV_MIN);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] div_cur_q, div_cur_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             tick_q, tick_d;
  logic             run_q, run_d;
  logic             accept, take, wrap;

  always_comb begin
    accept     = cfg_valid && ready_q;
    take       = accept && (cfg_div >= DIV_LO);
    err_d      = accept && !take;
    state_d    = state_q;
    div_cur_d  = div_cur_q;
    div_pend_d = div_pend_q;

    case (state_q)
      IDLE: begin
        if (take) div_cur_d = cfg_div;
        if (en)   state_d   = RUN;
      end
      RUN: begin
        // A ratio taken while stopping at this wrap has no later boundary to
        // wait for, so it is applied directly as in IDLE.
        if (take && (!wrap || en)) begin
          div_pend_d = cfg_div;
          state_d    = PEND;
        end else if (wrap) begin
          if (take) div_cur_d = cfg_div;
          if (!en)  state_d   = IDLE;
        end
      end
      PEND: begin
        if (wrap) begin
          div_cur_d = div_pend_q;
          state_d   = en ? RUN : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    run_d   = (state_d != IDLE);
    ready_d = (state_d != PEND);
    tick_d  = run_d && ((state_q == IDLE) || wrap);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      div_cur_q  <= DIV_RST;
      div_pend_q <= '0;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
      tick_q     <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cur_q  <= div_cur_d;
      div_pend_q <= div_pend_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
      tick_q     <= tick_d;
      run_q      <= run_d;
    end
  end

  clkdiv_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk     (clk),
    .rstn    (rstn),
    .div     (div_cur_q),
    .run     (run_d),
    .wrap    (wrap),
    .clk_out (clk_out)
  );

  assign cfg_ready   = ready_q;
  assign cfg_err     = err_q;
  assign period_tick = tick_q;
  assign div_cur     = div_cur_q;
  assign running     = run_q;

endmodule

// File: doc/clkdiv_ctrl.md
# clkdiv_ctrl

Programmable 50%-duty clock divider with a run/stop controller and handshaked divide-ratio reconfiguration. Ratio updates are applied only at output-period boundaries, so `clk_out` never glitches or produces a short pulse. It sits between the system configuration logic and any block that consumes a divided clock. It generalises the fixed odd-ratio divider to a runtime-selectable ratio N in 2..2^CNT_W-1.

## Interface
- `CNT_W`, 4: width of the period counter and the ratio fields.
- `DEF_DIV`, 5: ratio loaded into `div_cur` at reset. Must be in 2..2^CNT_W-1.
- `clk`  in  1: input clock. Sole clock domain; `clk_out` is generated from both edges of `clk`.
- `rstn`  in  1: asynchronous, active-low reset.
- `en`  in  1: run request. Level sensitive.
- `cfg_valid`  in  1: new ratio offered.
- `cfg_div`  in  CNT_W: offered ratio N.
- `cfg_ready`  out  1: controller can accept a ratio.
- `cfg_err`  out  1: one-cycle pulse when an illegal ratio is accepted.
- `clk_out`  out  1: divided clock.
- `period_tick`  out  1: one-cycle pulse in the first `clk` cycle of each output period.
- `div_cur`  out  CNT_W: ratio currently in effect.
- `running`  out  1: high while in RUN or PEND.

## Operation
- FSM states:
  - IDLE: stopped; `cnt` held at 0; `clk_out` low.
  - RUN: dividing.
  - PEND: dividing, with an accepted ratio waiting for the period boundary.
- Counter `cnt` runs 0..N-1 and wraps to 0. The cycle in which `cnt` = 0 is the period start, and `period_tick` is high in that cycle.
- Duty-cycle generation:
  - `pos_q` is a posedge flop that is high in the cycles where `cnt` < floor(N/2).
  - `neg_q` is a negedge flop that samples `pos_q`.
  - Even N: `clk_out` = `pos_q`, giving N/2 cycles high.
  - Odd N: `clk_out` = `pos_q | neg_q`, giving floor(N/2)+0.5 cycles high, i.e. 50% duty.
- Handshake: a transfer occurs on a `clk` rising edge with `cfg_valid` & `cfg_ready`. `cfg_ready` = 1 in IDLE and RUN, and 0 in PEND.
- Legal ratio = `cfg_div` >= 2. An accepted `cfg_div` of 0 or 1 pulses `cfg_err` in the next cycle, is discarded, and causes no state change.
- Accepting a legal ratio:
  - In IDLE: `div_cur` updates in the next cycle.
  - In RUN: the ratio is stored in `div_pend` and the FSM moves to PEND. At the edge where `cnt` = `div_cur`-1 wraps, `div_cur` ← `div_pend` and the FSM moves to RUN. The new period uses the new N from `cnt` = 0.
- IDLE→RUN: on an edge sampling `en` = 1. In the next cycle `cnt` = 0, `period_tick` = 1 and `clk_out` rises.
- `en` = 0 while in RUN or PEND: the current period completes. At the wrap edge the FSM goes to IDLE, applying any pending ratio first. `clk_out` therefore always stops low after a full period.
- `en` re-asserted before the wrap: no effect; running continues uninterrupted.
- Reset mid-operation: all state clears immediately. `clk_out` drops asynchronously. Any pending ratio is lost.

## Timing
- Reset values:
  - FSM = IDLE, `cnt` = 0
  - `pos_q` = `neg_q` = 0, so `clk_out` = 0
  - `div_cur` = `DEF_DIV`
  - `cfg_ready` = 1, `cfg_err` = 0, `period_tick` = 0, `running` = 0
- `cfg_err`: pulse in cycle t+1 for an acceptance at edge t.
- `div_cur` latency: 1 cycle when idle; up to N cycles when running (applied at the wrap).
- `running` rises 1 cycle after `en` is sampled high. It falls in the cycle after the final wrap.
- `clk_out` edges: the rising edge aligns to a `clk` rising edge. The falling edge aligns to a `clk` rising edge for even N and to a `clk` falling edge for odd N.
- No `clk_out` high or low phase is ever shorter than floor(N_min/2) `clk` cycles, where N_min is the smaller of the old and new ratios.
- Accept in the same cycle as the wrap (in RUN): the new ratio is stored, the current wrap uses the old N, and the new ratio applies at the next wrap.

## Structure
- Package `clkdiv_pkg` holds:
  - the state enum {IDLE, RUN, PEND}
  - `DIV_MIN` = 2
  - the default `CNT_W`
- Sub-module `clkdiv_core`: counter plus the `pos_q`/`neg_q` flops and the output OR. Inputs: `div`, `run`. Outputs: `wrap`, `clk_out`.
- `clkdiv_ctrl` contains the FSM, the handshake, `div_pend` and `cfg_err`.

## Test plan
- Reset, then `en` = 1 with the default ratio 5 → `clk_out` is high 2.5 cycles and low 2.5 cycles, `period_tick` pulses every 5 cycles, `div_cur` = 5.
- In IDLE, offer `cfg_div` = 4, then `en` = 1 → `div_cur` = 4 the next cycle; `clk_out` is high 2 cycles and low 2 cycles.
- While running N = 7, offer 3 mid-period:
  - `cfg_ready` falls.
  - The 7-cycle period completes.
  - The next period is 3 cycles (1.5 high).
  - `cfg_ready` returns to 1.
  - No short pulse appears.
- Offer `cfg_div` = 1 and then `cfg_div` = 0 → each produces a one-cycle `cfg_err` pulse; `div_cur` and the period are unchanged.
- Drop `en` at `cnt` = 1 with N = 6 → the period finishes at `cnt` = 5, `clk_out` ends low, `running` = 0; the next `en` = 1 starts at `cnt` = 0.
- Assert `rstn` = 0 mid-high phase with N = 9 and a ratio pending → `clk_out` is 0 immediately, `div_cur` = 5, `cfg_ready` = 1, and the pending ratio is discarded.
